// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU MEM stage,
// DMA burst port) and the single-port synchronous RAM.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
);
  logic              cpu_re;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wready;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_wready, dma_rdata, dma_rvalid, dma_done,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  // requesters + memory side
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_wready, dma_rdata, dma_rvalid, dma_done,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port data memory between the CPU MEM stage
// (default priority) and a DMA burst engine, with a starvation guard for DMA.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = 5,
  parameter int STARVE_LIM = 8
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int SC_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, CPU_RD, DMA, DMA_END} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              we_reg, we_next;
  logic [LEN_W-1:0]  beat_reg, beat_next;
  logic [SC_W-1:0]   starve_reg, starve_next;
  logic              prio_reg, prio_next;
  logic              rvalid_reg;

  logic              cpu_req, dma_grant;
  logic [LEN_W-1:0]  len_clamp;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, cpu_rdata_c;
  logic              mem_we_c, mem_re_c, cpu_stall_c, dma_wready_c, dma_done_c;

  assign cpu_req   = bus.cpu_re | bus.cpu_we;
  assign len_clamp = (bus.dma_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.dma_len;

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    len_next     = len_reg;
    we_next      = we_reg;
    beat_next    = beat_reg;
    starve_next  = starve_reg;
    prio_next    = prio_reg;
    dma_grant    = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    cpu_stall_c  = 1'b0;
    cpu_rdata_c  = '0;
    dma_wready_c = 1'b0;
    dma_done_c   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.dma_req && (!cpu_req || prio_reg)) begin
          dma_grant   = 1'b1;
          addr_next   = bus.dma_addr;
          len_next    = len_clamp;
          we_next     = bus.dma_we;
          beat_next   = '0;
          cpu_stall_c = cpu_req;
          state_next  = (len_clamp == '0) ? DMA_END : DMA;
        end else if (cpu_req) begin
          mem_addr_c = bus.cpu_addr;
          if (bus.cpu_we) begin
            // a store completes in the cycle it is presented
            mem_we_c    = 1'b1;
            mem_wdata_c = bus.cpu_wdata;
          end else begin
            mem_re_c    = 1'b1;
            cpu_stall_c = 1'b1;
            state_next  = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        cpu_rdata_c = bus.mem_rdata;
        state_next  = IDLE;
      end
      DMA: begin
        cpu_stall_c = cpu_req;
        mem_addr_c  = addr_reg + ADDR_W'(beat_reg);
        if (we_reg) begin
          mem_we_c     = 1'b1;
          mem_wdata_c  = bus.dma_wdata;
          dma_wready_c = 1'b1;
        end else begin
          mem_re_c = 1'b1;
        end
        beat_next = beat_reg + 1'b1;
        if (beat_reg == len_reg - 1'b1)
          state_next = DMA_END;
      end
      DMA_END: begin
        cpu_stall_c = cpu_req;
        dma_done_c  = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Waiting only counts while the memory is not already serving a DMA burst.
    if (dma_grant) begin
      starve_next = '0;
      prio_next   = 1'b0;
    end else if (bus.dma_req && (state_reg == IDLE || state_reg == CPU_RD)) begin
      if (starve_reg != SC_W'(STARVE_LIM))
        starve_next = starve_reg + 1'b1;
      if (starve_next == SC_W'(STARVE_LIM))
        prio_next = 1'b1;
    end

    // Reset must never leak a strobe, even though the requesters may be active.
    if (!rst_n) begin
      mem_addr_c   = '0;
      mem_wdata_c  = '0;
      mem_we_c     = 1'b0;
      mem_re_c     = 1'b0;
      cpu_rdata_c  = '0;
      dma_wready_c = 1'b0;
      dma_done_c   = 1'b0;
      cpu_stall_c  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      we_reg     <= 1'b0;
      beat_reg   <= '0;
      starve_reg <= '0;
      prio_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      we_reg     <= we_next;
      beat_reg   <= beat_next;
      starve_reg <= starve_next;
      prio_reg   <= prio_next;
      rvalid_reg <= (state_reg == DMA) && !we_reg;
    end
  end

  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_re     = mem_re_c;
  assign bus.cpu_stall  = cpu_stall_c;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.dma_wready = dma_wready_c;
  assign bus.dma_done   = dma_done_c;
  assign bus.dma_rvalid = rvalid_reg;
  assign bus.dma_rdata  = rvalid_reg ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus queues cycle-stamped
// expectations, a negedge monitor pops them as the DUT emits memory/DMA/CPU events.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // synchronous RAM model
  logic [31:0] ram [0:65535];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rd_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [31:0] d;
    bit          cpu;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t dq[$];
  ev_t lq[$];
  int  doneq[$];
  int  tests = 0;
  int  fails = 0;

  function automatic ev_t mk(int c, logic [15:0] a, logic [31:0] d, bit cpu);
    ev_t e;
    e.c = c; e.a = a; e.d = d; e.cpu = cpu;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (bus.mem_we || bus.dma_wready) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL write: unexpected at cycle %0d addr=%h data=%h wready=%b", cyc, bus.mem_addr, bus.mem_wdata, bus.dma_wready);
      end else begin
        e = wq.pop_front();
        if (e.c != cyc || !bus.mem_we || e.a != bus.mem_addr || e.d != bus.mem_wdata ||
            (e.cpu ? (bus.cpu_stall || bus.dma_wready) : !bus.dma_wready)) begin
          fails++;
          $display("FAIL write: got cyc=%0d we=%b addr=%h data=%h stall=%b wready=%b, expected cyc=%0d addr=%h data=%h cpu=%0d",
                   cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_stall, bus.dma_wready, e.c, e.a, e.d, e.cpu);
        end else
          $display("[TB] cyc %0d write addr=%h data=%h %s", cyc, e.a, e.d, e.cpu ? "cpu" : "dma");
      end
    end
    if (bus.mem_re) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL read_strobe: unexpected at cycle %0d addr=%h", cyc, bus.mem_addr);
      end else begin
        e = rq.pop_front();
        if (e.c != cyc || e.a != bus.mem_addr) begin
          fails++;
          $display("FAIL read_strobe: got cyc=%0d addr=%h, expected cyc=%0d addr=%h", cyc, bus.mem_addr, e.c, e.a);
        end else
          $display("[TB] cyc %0d read strobe addr=%h", cyc, e.a);
      end
    end
    if (bus.dma_rvalid) begin
      tests++;
      if (dq.size() == 0) begin
        fails++;
        $display("FAIL dma_rvalid: unexpected at cycle %0d data=%h", cyc, bus.dma_rdata);
      end else begin
        e = dq.pop_front();
        if (e.c != cyc || e.d != bus.dma_rdata) begin
          fails++;
          $display("FAIL dma_rvalid: got cyc=%0d data=%h, expected cyc=%0d data=%h", cyc, bus.dma_rdata, e.c, e.d);
        end else
          $display("[TB] cyc %0d dma read beat data=%h", cyc, e.d);
      end
    end
    if (bus.dma_done) begin
      tests++;
      if (doneq.size() == 0) begin
        fails++;
        $display("FAIL dma_done: unexpected at cycle %0d", cyc);
      end else begin
        int c;
        c = doneq.pop_front();
        if (c != cyc) begin
          fails++;
          $display("FAIL dma_done: got cyc=%0d expected cyc=%0d", cyc, c);
        end else
          $display("[TB] cyc %0d dma done", cyc);
      end
    end
    if (bus.cpu_re && !bus.cpu_we && !bus.cpu_stall) begin
      tests++;
      if (lq.size() == 0) begin
        fails++;
        $display("FAIL cpu_load: unexpected completion at cycle %0d data=%h", cyc, bus.cpu_rdata);
      end else begin
        e = lq.pop_front();
        if (e.c != cyc || e.d != bus.cpu_rdata) begin
          fails++;
          $display("FAIL cpu_load: got cyc=%0d data=%h, expected cyc=%0d data=%h", cyc, bus.cpu_rdata, e.c, e.d);
        end else
          $display("[TB] cyc %0d cpu load data=%h", cyc, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;
  endtask

  // Uncontended burst: grant in the request cycle, beats follow back to back.
  task automatic dma_burst(input bit we, input logic [15:0] a, input logic [4:0] len,
                           input logic [31:0] base, input bit cpu_ld);
    int n;
    n = (len > 5'd16) ? 16 : int'(len);
    tick(); clear_in();
    bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_len = len;
    for (int b = 0; b < n; b++) begin
      tick();
      bus.dma_req = 0;
      bus.dma_wdata = base + 32'(b);
      if (cpu_ld && b == 1) begin bus.cpu_re = 1; bus.cpu_addr = 16'h0010; end
      if (we) wq.push_back(mk(cyc, 16'(a + 16'(b)), base + 32'(b), 0));
      else begin
        rq.push_back(mk(cyc, 16'(a + 16'(b)), '0, 0));
        dq.push_back(mk(cyc + 1, '0, base + 32'(b), 0));
      end
      if (cpu_ld && b >= 1) begin @(negedge clk); chk("stall_in_burst", bus.cpu_stall, 1); end
    end
    tick();
    bus.dma_req = 0;
    doneq.push_back(cyc);
    if (cpu_ld) begin
      @(negedge clk); chk("stall_in_dma_end", bus.cpu_stall, 1);
      tick(); rq.push_back(mk(cyc, 16'h0010, '0, 1));
      tick(); lq.push_back(mk(cyc, '0, 32'hDEADBEEF, 1));
    end
    tick(); clear_in();
  endtask

  // CPU stores every cycle while DMA waits; DMA must win after STARVE_LIM cycles.
  task automatic starve_round(input logic [15:0] ca, input logic [15:0] da, input logic [31:0] dd);
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = da; bus.dma_len = 5'd1;
      bus.cpu_we = 1; bus.cpu_addr = 16'(ca + 16'(k)); bus.cpu_wdata = 32'h100 + 32'(k);
      wq.push_back(mk(cyc, 16'(ca + 16'(k)), 32'h100 + 32'(k), 1));
    end
    tick();
    bus.cpu_addr = 16'(ca + 16'd8); bus.cpu_wdata = 32'h108;
    @(negedge clk); chk("starve_grant_stall", bus.cpu_stall, 1);
    tick(); bus.dma_req = 0; bus.dma_wdata = dd;
    wq.push_back(mk(cyc, da, dd, 0));
    tick(); doneq.push_back(cyc);
    tick(); wq.push_back(mk(cyc, 16'(ca + 16'd8), 32'h108, 1));
    tick(); clear_in();
  endtask

  initial begin
    clear_in();
    // requests asserted during reset must not reach the memory
    bus.cpu_we = 1; bus.cpu_addr = 16'h0005; bus.cpu_wdata = 32'h1;
    bus.dma_req = 1; bus.dma_len = 5'd3;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 1);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_dma_done", bus.dma_done, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    tick(); clear_in(); rst_n = 1;
    @(negedge clk); chk("idle_stall", bus.cpu_stall, 0);

    tick(); bus.cpu_we = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEADBEEF;
    wq.push_back(mk(cyc, 16'h0010, 32'hDEADBEEF, 1));
    tick(); bus.cpu_we = 0; bus.cpu_re = 1;
    rq.push_back(mk(cyc, 16'h0010, '0, 1));
    @(negedge clk); chk("load_stall_first", bus.cpu_stall, 1);
    tick(); lq.push_back(mk(cyc, '0, 32'hDEADBEEF, 1));
    tick(); clear_in();
    // re and we together behave as a store
    tick(); bus.cpu_re = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0011; bus.cpu_wdata = 32'h12345678;
    wq.push_back(mk(cyc, 16'h0011, 32'h12345678, 1));
    tick(); clear_in();

    dma_burst(1, 16'h0100, 5'd4, 32'd1, 0);
    dma_burst(0, 16'h0100, 5'd4, 32'd1, 0);
    dma_burst(1, 16'hFFFF, 5'd3, 32'h30, 0);
    dma_burst(0, 16'hFFFF, 5'd3, 32'h30, 0);
    dma_burst(1, 16'h0200, 5'd8, 32'h80, 1);
    dma_burst(1, 16'h0500, 5'd0, 32'h0, 0);
    dma_burst(1, 16'h0600, 5'd20, 32'h600, 0);

    starve_round(16'h0400, 16'h0300, 32'hAAAA0000);
    starve_round(16'h0410, 16'h0310, 32'hBBBB0000);

    // reset at beat 2 of an 8-beat write burst
    tick(); clear_in();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0700; bus.dma_len = 5'd8;
    tick(); bus.dma_req = 0; bus.dma_wdata = 32'h70; wq.push_back(mk(cyc, 16'h0700, 32'h70, 0));
    tick(); bus.dma_wdata = 32'h71; wq.push_back(mk(cyc, 16'h0701, 32'h71, 0));
    tick(); bus.dma_wdata = 32'h72; rst_n = 0;
    @(negedge clk);
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_wready", bus.dma_wready, 0);
    tick();
    tick(); rst_n = 1; clear_in();
    bus.cpu_we = 1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 32'h55;
    wq.push_back(mk(cyc, 16'h0020, 32'h55, 1));
    tick(); clear_in();
    repeat (12) tick();

    tests++;
    if (wq.size() + rq.size() + dq.size() + lq.size() + doneq.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d unmatched expectations, expected 0",
               wq.size() + rq.size() + dq.size() + lq.size() + doneq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
